pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 224, payload width (datapath fields: shifter, mem, ALU, HiLo, 64-bit HiLo source).
REQ-002 SHALL have parameter CTRL_W, default 10, control width (RegWrite, MemtoReg, Shift, Mf, HiLoWrite, WN[4:0]).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream stage holds a valid instruction.
REQ-006 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-007 SHALL have port in_ctrl  input  CTRL_W  upstream control bits.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port out_valid  output  1  downstream instruction valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have port out_ctrl  output  CTRL_W  control to downstream; zero whenever out_valid=0.
REQ-012 SHALL have port out_data  output  DATA_W  payload to downstream.
REQ-013 SHALL have port flush  input  1  squash all held instructions.
REQ-014 SHALL have port occupancy  output  2  held entries, 0..2.

Function
REQ-015 SHALL hold a main entry and a skid entry; states EMPTY (0 held), BUSY (1), FULL (2).
REQ-016 Transfer SHALL occur on an edge where valid&ready on that side.
REQ-017 in_ready SHALL be registered: 1 in EMPTY/BUSY, 0 in FULL; no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 in BUSY/FULL, 0 in EMPTY; out_ctrl/out_data SHALL come from the main entry.
REQ-019 EMPTY + input transfer -> BUSY, main loads input; latency 1 cycle input to output.
REQ-020 BUSY + input transfer + output transfer -> BUSY, main loads input.
REQ-021 BUSY + input transfer, no output transfer -> FULL, skid loads input, main holds.
REQ-022 BUSY + output transfer only -> EMPTY.
REQ-023 FULL + output transfer -> BUSY, main loads skid; FULL otherwise holds.
REQ-024 Order SHALL be preserved; no entry dropped or duplicated absent flush/reset.
REQ-025 occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL.
REQ-026 flush=1 SHALL force EMPTY next cycle, discarding both entries and any same-cycle input.
REQ-027 flush and out_ready same cycle: the current main entry SHALL count as transferred; held entries still discarded.
REQ-028 out_data in EMPTY SHALL hold its last value; only control is zeroed.

Reset
REQ-029 rst SHALL force state EMPTY, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, skid contents=0 at next edge.
REQ-030 rst SHALL take priority over flush and transfers, including mid-operation in FULL.

Configuration
REQ-031 Macro PIPE_STAGE_FLUSH_EN defined: flush behaves per REQ-026/027.
REQ-032 Macro PIPE_STAGE_FLUSH_EN undefined: flush port present but ignored; no flush logic synthesised.

Structure
REQ-033 Shared package pipe_pkg SHALL hold the state typedef (EMPTY, BUSY, FULL) and default DATA_W/CTRL_W constants.
REQ-034 Sub-module pipe_data_reg (enable-load register, CTRL_W+DATA_W wide, sync clear) SHALL be instanced twice, main and skid.

Verification
REQ-035 rst, then in_valid=1, in_ctrl=0x3FF, in_data=0xA5.., out_ready=1 -> next cycle out_valid=1, out_ctrl=0x3FF, occupancy=1.
REQ-036 Push A,B with out_ready=0 -> occupancy=2, in_ready=0; raise out_ready -> A then B on consecutive cycles.
REQ-037 Continuous in_valid=1, out_ready=1 for 100 items 0..99 -> out_data sequence 0..99 with no gaps after first cycle.
REQ-038 FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; without PIPE_STAGE_FLUSH_EN -> state unchanged.
REQ-039 FULL, rst=1 with flush=1 and out_ready=1 -> all outputs zero, in_ready=1 next cycle.
REQ-040 Random valid/ready (50%), 10k cycles, scoreboard -> output stream equals input stream, in order.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
//==============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipe_stage_reg block:
//               occupancy state encoding and default field widths.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package pipe_pkg;

  // Default payload width: shifter, mem, ALU, HiLo and 64-bit HiLo source fields
  localparam int c_DATA_W_DEFAULT = 224;
  // Default control width: RegWrite, MemtoReg, Shift, Mf, HiLoWrite, WN[4:0]
  localparam int c_CTRL_W_DEFAULT = 10;

  // Number of held entries doubles as the state encoding
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Held-entry count for a state; the unused encoding reports zero
  function automatic logic [1:0] occ_of(input state_t s);
    logic [1:0] v;
    case (s)
      ST_BUSY: v = 2'd1;
      ST_FULL: v = 2'd2;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
//==============================================================================
// Module      : pipe_stage_reg_if
// Description : Upstream/downstream handshake bundle of one pipeline stage.
//               master = environment side, slave = stage side.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

interface pipe_stage_reg_if #(
  parameter int DATA_W = pipe_pkg::c_DATA_W_DEFAULT,
  parameter int CTRL_W = pipe_pkg::c_CTRL_W_DEFAULT
);

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready, flush,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready, flush,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg_data_reg.sv
//==============================================================================
// Module      : pipe_data_reg
// Description : Enable-load register with synchronous clear; holds one
//               {ctrl, data} pipeline entry.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module pipe_data_reg #(
  parameter int WIDTH = pipe_pkg::c_CTRL_W_DEFAULT + pipe_pkg::c_DATA_W_DEFAULT
) (
  input  wire logic             clk,
  input  wire logic             i_clr,
  input  wire logic             i_en,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Clear wins over load; otherwise hold
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
//==============================================================================
// Module      : pipe_stage_reg
// Description : Two-entry (main + skid) pipeline stage register with a fully
//               registered in_ready. Output always comes from the main entry;
//               control is zeroed while no entry is held.
//               Optional feature macro: PIPE_STAGE_FLUSH_EN (enables flush).
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module pipe_stage_reg import pipe_pkg::*; #(
  parameter int DATA_W = c_DATA_W_DEFAULT,
  parameter int CTRL_W = c_CTRL_W_DEFAULT
) (
  input wire logic        clk,
  input wire logic        rst,
  pipe_stage_reg_if.slave bus
);

  localparam int c_ENTRY_W = CTRL_W + DATA_W;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_in_ready;
  logic                 w_out_valid;
  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_flush;
  logic                 w_main_en;
  logic                 w_main_from_skid;
  logic                 w_skid_en;
  logic [c_ENTRY_W-1:0] w_in_entry;
  logic [c_ENTRY_W-1:0] w_main_d;
  logic [c_ENTRY_W-1:0] w_main_q;
  logic [c_ENTRY_W-1:0] w_skid_q;

  assign w_in_entry  = {bus.in_ctrl, bus.in_data};
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_xfer   = bus.in_valid & r_in_ready;
  assign w_out_xfer  = w_out_valid & bus.out_ready;

`ifdef PIPE_STAGE_FLUSH_EN
  assign w_flush = bus.flush;
`else
  // Flush port is accepted but has no effect in this build
  assign w_flush = 1'b0;
`endif

  // State register; in_ready is precomputed from the next state so it never
  // depends combinationally on out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != ST_FULL);
    end
  end

  // Next-state: occupancy moves by +1 per accepted input, -1 per delivered output
  always_comb begin
    w_next_state = r_state;
    if (w_flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) w_next_state = ST_BUSY;
        end
        ST_BUSY: begin
          if (w_in_xfer && !w_out_xfer)      w_next_state = ST_FULL;
          else if (!w_in_xfer && w_out_xfer) w_next_state = ST_EMPTY;
        end
        ST_FULL: begin
          if (w_out_xfer) w_next_state = ST_BUSY;
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  // Entry load controls: main takes the input unless an older entry waits in skid
  always_comb begin
    w_main_en        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_en        = 1'b0;
    if (!w_flush) begin
      case (r_state)
        ST_EMPTY: begin
          w_main_en = w_in_xfer;
        end
        ST_BUSY: begin
          w_main_en = w_in_xfer & w_out_xfer;
          w_skid_en = w_in_xfer & ~w_out_xfer;
        end
        ST_FULL: begin
          w_main_en        = w_out_xfer;
          w_main_from_skid = 1'b1;
        end
        default: begin
          w_main_en = 1'b0;
        end
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_entry;

  pipe_data_reg #(.WIDTH(c_ENTRY_W)) u_main (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (w_main_en),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  pipe_data_reg #(.WIDTH(c_ENTRY_W)) u_skid (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (w_skid_en),
    .i_d   (w_in_entry),
    .o_q   (w_skid_q)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ctrl  = w_out_valid ? w_main_q[c_ENTRY_W-1 -: CTRL_W] : '0;
  assign bus.out_data  = w_main_q[DATA_W-1:0];
  assign bus.occupancy = occ_of(r_state);

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
//==============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg: directed vector table,
//               a 100-item streaming sequence and randomized traffic against a
//               queue-based reference model. Honours PIPE_STAGE_FLUSH_EN.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 224;
  localparam int CW = 10;
`ifdef PIPE_STAGE_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic          rst, iv, fl, ordy;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic          e_ir, e_ov;
    logic [CW-1:0] e_ctrl;
    logic [1:0]    e_occ;
    logic [DW-1:0] e_data;
  } vec_t;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  vec_t          tbl [14];
  ent_t          mq [$];
  logic [DW-1:0] m_last;

  function automatic vec_t mk(input logic r, iv, fl, ordy, input logic [CW-1:0] c,
                              input logic [DW-1:0] d, input logic eir, eov,
                              input logic [CW-1:0] ec, input logic [1:0] eocc,
                              input logic [DW-1:0] ed);
    vec_t v;
    v.rst = r; v.iv = iv; v.fl = fl; v.ordy = ordy; v.ctrl = c; v.data = d;
    v.e_ir = eir; v.e_ov = eov; v.e_ctrl = ec; v.e_occ = eocc; v.e_data = ed;
    return v;
  endfunction

  task automatic drive(input logic r, iv, fl, ordy, input logic [CW-1:0] c,
                       input logic [DW-1:0] d);
    rst           = r;
    bus.in_valid  = iv;
    bus.flush     = fl;
    bus.out_ready = ordy;
    bus.in_ctrl   = c;
    bus.in_data   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ir, ov, input logic [CW-1:0] c,
                       input logic [1:0] occ, input logic [DW-1:0] d);
    vectors++;
    if (bus.in_ready !== ir || bus.out_valid !== ov || bus.out_ctrl !== c ||
        bus.occupancy !== occ || bus.out_data !== d) begin
      miscompares++;
      $display("FAIL %s: got ir=%b ov=%b ctrl=%h occ=%0d data=%h | want ir=%b ov=%b ctrl=%h occ=%0d data=%h",
               name, bus.in_ready, bus.out_valid, bus.out_ctrl, bus.occupancy, bus.out_data,
               ir, ov, c, occ, d);
    end
  endtask

  // Reference model: FIFO of at most two entries, advanced once per clock edge
  task automatic model_edge(input logic r, iv, fl, ordy, input logic [CW-1:0] c,
                            input logic [DW-1:0] d);
    bit   in_x;
    bit   out_x;
    ent_t e;
    in_x  = iv && (mq.size() < 2);
    out_x = (mq.size() > 0) && ordy;
    if (r) begin
      mq.delete();
      m_last = '0;
    end else if (fl && FLUSH_EN) begin
      if (mq.size() > 0) m_last = mq[0].data;
      mq.delete();
    end else begin
      if (out_x) begin
        m_last = mq[0].data;
        void'(mq.pop_front());
      end
      if (in_x) begin
        e.ctrl = c;
        e.data = d;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_model(input string name);
    logic          ov;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    ov = (mq.size() > 0);
    c  = ov ? mq[0].ctrl : '0;
    d  = ov ? mq[0].data : m_last;
    check(name, mq.size() != 2, ov, c, 2'(mq.size()), d);
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] pat_a;
    logic          r, iv, fl, ordy;
    logic [CW-1:0] c;
    logic [DW-1:0] d;

    pat_a = {28{8'hA5}};
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

    // rst, iv, fl, ordy, ctrl, data  ->  in_ready, out_valid, out_ctrl, occupancy, out_data
    tbl[0]  = mk(1, 0, 0, 0, 10'h000, '0,         1, 0, 10'h000, 2'd0, '0);
    tbl[1]  = mk(0, 1, 0, 1, 10'h3FF, pat_a,      1, 1, 10'h3FF, 2'd1, pat_a);
    tbl[2]  = mk(0, 1, 0, 0, 10'h001, DW'(1),     0, 1, 10'h3FF, 2'd2, pat_a);
    tbl[3]  = mk(0, 1, 0, 0, 10'h002, DW'(2),     0, 1, 10'h3FF, 2'd2, pat_a);
    tbl[4]  = mk(0, 0, 0, 1, 10'h000, '0,         1, 1, 10'h001, 2'd1, DW'(1));
    tbl[5]  = mk(0, 0, 0, 1, 10'h000, '0,         1, 0, 10'h000, 2'd0, DW'(1));
    tbl[6]  = mk(0, 1, 0, 0, 10'h005, DW'(5),     1, 1, 10'h005, 2'd1, DW'(5));
    tbl[7]  = mk(0, 1, 0, 0, 10'h006, DW'(6),     0, 1, 10'h005, 2'd2, DW'(5));
`ifdef PIPE_STAGE_FLUSH_EN
    tbl[8]  = mk(0, 1, 1, 0, 10'h007, DW'(7),     1, 0, 10'h000, 2'd0, DW'(5));
`else
    tbl[8]  = mk(0, 1, 1, 0, 10'h007, DW'(7),     0, 1, 10'h005, 2'd2, DW'(5));
`endif
    tbl[9]  = mk(1, 1, 1, 1, 10'h007, DW'(7),     1, 0, 10'h000, 2'd0, '0);
    tbl[10] = mk(0, 1, 0, 0, 10'h008, DW'(8),     1, 1, 10'h008, 2'd1, DW'(8));
    tbl[11] = mk(0, 1, 0, 0, 10'h009, DW'(9),     0, 1, 10'h008, 2'd2, DW'(8));
    tbl[12] = mk(1, 1, 1, 1, 10'h00A, DW'(10),    1, 0, 10'h000, 2'd0, '0);
    tbl[13] = mk(0, 0, 0, 0, 10'h000, '0,         1, 0, 10'h000, 2'd0, '0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].fl, tbl[i].ordy, tbl[i].ctrl, tbl[i].data);
      tick();
      check($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_ctrl,
            tbl[i].e_occ, tbl[i].e_data);
    end

    // Back-to-back stream: one item out per cycle, one cycle behind its input
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, CW'(k + 1), DW'(k));
      tick();
      check($sformatf("stream%0d", k), 1'b1, 1'b1, CW'(k + 1), 2'd1, DW'(k));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    check("stream_drain", 1'b1, 1'b0, '0, 2'd0, DW'(99));

    // Randomized traffic against the reference model
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    model_edge(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    check_model("rand_reset");
    for (int n = 0; n < 10000; n++) begin
      r    = ($urandom_range(0, 199) == 0);
      iv   = $urandom_range(0, 1) == 1;
      fl   = ($urandom_range(0, 49) == 0);
      ordy = $urandom_range(0, 1) == 1;
      c    = CW'($urandom);
      d    = rand_data();
      drive(r, iv, fl, ordy, c, d);
      model_edge(r, iv, fl, ordy, c, d);
      tick();
      check_model($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
